// File: rtl/issue_queue_if.sv
// Fetch/issue handshake bundle for issue_queue. Packets are flat vectors:
// [64] valid, [63:32] pc, [31:0] inst.
interface issue_queue_if #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ENQ_WIDTH = 2,
  parameter int unsigned DEQ_WIDTH = 2,
  parameter int unsigned MAX_BR    = 2,
  parameter int unsigned PKT_W     = 65
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned BrW  = $clog2(MAX_BR + 1);

  logic [ENQ_WIDTH-1:0]            enq_valid;
  logic [ENQ_WIDTH-1:0][PKT_W-1:0] enq_packet;
  logic                            enq_ready;
  logic [DEQ_WIDTH-1:0]            deq_valid;
  logic [DEQ_WIDTH-1:0][PKT_W-1:0] deq_packet;
  logic [DEQ_WIDTH-1:0]            deq_spec;
  logic [DEQ_WIDTH-1:0]            deq_ready;
  logic                            kill;
  logic                            resolve;
  logic [CntW-1:0]                 count;
  logic [BrW-1:0]                  br_outstanding;
  logic                            halt_latched;

  modport master (
    output enq_valid, enq_packet, deq_ready, kill, resolve,
    input  enq_ready, deq_valid, deq_packet, deq_spec, count, br_outstanding, halt_latched
  );

  modport slave (
    input  enq_valid, enq_packet, deq_ready, kill, resolve,
    output enq_ready, deq_valid, deq_packet, deq_spec, count, br_outstanding, halt_latched
  );
endinterface

// File: rtl/issue_queue.sv
// In-order multi-lane instruction buffer between fetch and decode, with speculation
// tagging, conditional-branch throttling, WFI halt latch and full flush on kill.
module issue_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ENQ_WIDTH = 2,
  parameter int unsigned DEQ_WIDTH = 2,
  parameter int unsigned MAX_BR    = 2
) (
  input logic            clock,
  input logic            reset,
  issue_queue_if.slave   bus
);
  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = $clog2(DEPTH + 1);
  localparam int unsigned BrW    = $clog2(MAX_BR + 1);
  localparam int unsigned PktW   = 65;
  localparam int unsigned VldBit = 64;
  localparam logic [31:0] InstWfi  = 32'h1050_0073;
  localparam logic [6:0]  OpBranch = 7'b110_0011;

  logic [PktW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [BrW-1:0]  br_q, br_d;
  logic            halt_q, halt_d;

  logic                           enq_ready;
  logic [ENQ_WIDTH-1:0]           wr_en;
  logic [ENQ_WIDTH-1:0][PtrW-1:0] wr_idx;
  logic                           halt_set;
  int unsigned                    enq_n, deq_n, br_fired;

  logic [DEQ_WIDTH-1:0]           deq_valid, deq_spec;
  logic [DEQ_WIDTH-1:0][PktW-1:0] deq_packet;

  // Whole-group admission, from registered state only.
  assign enq_ready = (int'(DEPTH) - int'(count_q) >= int'(ENQ_WIDTH)) && !halt_q;

  always_comb begin
    logic alive;
    wr_en    = '0;
    wr_idx   = '0;
    enq_n    = 0;
    halt_set = 1'b0;
    alive    = enq_ready && bus.enq_valid[0];
    for (int i = 0; i < int'(ENQ_WIDTH); i++) begin
      if (!bus.enq_valid[i]) alive = 1'b0;
      if (alive && bus.enq_packet[i][VldBit]) begin
        wr_en[i]  = 1'b1;
        wr_idx[i] = tail_q + PtrW'(enq_n);
        enq_n     = enq_n + 1;
        // WFI is kept; anything younger in the group is discarded.
        if (bus.enq_packet[i][31:0] == InstWfi) begin
          halt_set = 1'b1;
          alive    = 1'b0;
        end
      end
    end
  end

  always_comb begin
    int unsigned     b;
    logic            open, take, occ, is_br;
    logic [PtrW-1:0] rd_idx;
    logic [PktW-1:0] ent;
    deq_valid  = '0;
    deq_spec   = '0;
    deq_packet = '0;
    deq_n      = 0;
    br_fired   = 0;
    b          = 0;
    open       = 1'b1;
    take       = 1'b1;
    for (int i = 0; i < int'(DEQ_WIDTH); i++) begin
      rd_idx        = head_q + PtrW'(i);
      ent           = mem_q[rd_idx];
      occ           = int'(count_q) > i;
      is_br         = occ && (ent[6:0] == OpBranch);
      deq_packet[i] = ent;
      deq_spec[i]   = (32'(br_q) + b) != 0;
      // A throttled branch closes this lane and every younger one.
      if (!occ || (is_br && (32'(br_q) + b >= MAX_BR))) open = 1'b0;
      deq_valid[i] = open;
      take         = take && open && bus.deq_ready[i];
      if (take) begin
        deq_n = deq_n + 1;
        if (is_br) br_fired = br_fired + 1;
      end
      if (is_br) b = b + 1;
    end
  end

  always_comb begin
    head_d  = head_q + PtrW'(deq_n);
    tail_d  = tail_q + PtrW'(enq_n);
    count_d = count_q + CntW'(enq_n) - CntW'(deq_n);
    br_d    = br_q + BrW'(br_fired);
    if (bus.resolve && (br_d != '0)) br_d = br_d - BrW'(1);
    halt_d  = halt_q | halt_set;
    if (bus.kill) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      br_d    = '0;
      halt_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      br_q    <= '0;
      halt_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      br_q    <= br_d;
      halt_q  <= halt_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < int'(ENQ_WIDTH); i++) begin
      if (wr_en[i] && !bus.kill) mem_q[wr_idx[i]] <= bus.enq_packet[i];
    end
  end

  assign bus.enq_ready      = enq_ready;
  assign bus.deq_valid      = deq_valid;
  assign bus.deq_packet     = deq_packet;
  assign bus.deq_spec       = deq_spec;
  assign bus.count          = count_q;
  assign bus.br_outstanding = br_q;
  assign bus.halt_latched   = halt_q;
endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: fill/drain, prefix rules, branch throttle, halt,
// kill collision, wrap-around and asynchronous reset.
module tb_issue_queue;
  localparam logic [31:0] InstAdd = 32'h0000_0033;
  localparam logic [31:0] InstBeq = 32'h0000_0063;
  localparam logic [31:0] InstBne = 32'h0000_1063;
  localparam logic [31:0] InstWfi = 32'h1050_0073;

  logic clock;
  logic reset;
  int   tests_run;
  int   tests_failed;

  issue_queue_if #(.DEPTH(8), .ENQ_WIDTH(2), .DEQ_WIDTH(2), .MAX_BR(2), .PKT_W(65)) bus ();

  issue_queue #(.DEPTH(8), .ENQ_WIDTH(2), .DEQ_WIDTH(2), .MAX_BR(2)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [64:0] mk(input logic v, input logic [31:0] pc,
                                     input logic [31:0] inst);
    return {v, pc, inst};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic enq2(input logic [1:0] v, input logic [64:0] a, input logic [64:0] b);
    bus.enq_valid     = v;
    bus.enq_packet[0] = a;
    bus.enq_packet[1] = b;
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b0;
    bus.enq_valid = '0;
    bus.enq_packet = '0;
    bus.deq_ready = '0;
    bus.kill      = 1'b0;
    bus.resolve   = 1'b0;
    #3;
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_deq_valid", 64'(bus.deq_valid), 64'd0);
    check("rst_enq_ready", 64'(bus.enq_ready), 64'd1);
    check("rst_deq_spec", 64'(bus.deq_spec), 64'd0);
    check("rst_br", 64'(bus.br_outstanding), 64'd0);
    check("rst_halt", 64'(bus.halt_latched), 64'd0);
    #9 reset = 1'b1;
    tick();

    // Fill / drain
    for (int g = 0; g < 4; g++) begin
      enq2(2'b11, mk(1'b1, 32'(g * 8), InstAdd), mk(1'b1, 32'(g * 8 + 4), InstAdd));
      check("fill_ready", 64'(bus.enq_ready), 64'd1);
      tick();
    end
    check("full_count", 64'(bus.count), 64'd8);
    check("full_enq_ready", 64'(bus.enq_ready), 64'd0);
    tick();
    check("full_hold", 64'(bus.count), 64'd8);
    bus.enq_valid = '0;
    bus.deq_ready = 2'b11;
    for (int c = 0; c < 4; c++) begin
      check("drain_valid", 64'(bus.deq_valid), 64'd3);
      check("drain_pc0", 64'(bus.deq_packet[0][63:32]), 64'(c * 8));
      check("drain_pc1", 64'(bus.deq_packet[1][63:32]), 64'(c * 8 + 4));
      tick();
    end
    check("empty_count", 64'(bus.count), 64'd0);
    check("empty_ready", 64'(bus.enq_ready), 64'd1);
    check("empty_valid", 64'(bus.deq_valid), 64'd0);
    bus.deq_ready = '0;

    // Prefix rules
    enq2(2'b10, mk(1'b1, 32'h100, InstAdd), mk(1'b1, 32'h104, InstAdd));
    tick();
    check("prefix_lane0_off", 64'(bus.count), 64'd0);
    enq2(2'b11, mk(1'b1, 32'h100, InstAdd), mk(1'b1, 32'h104, InstAdd));
    tick();
    bus.enq_valid = '0;
    bus.deq_ready = 2'b10;
    tick();
    check("lane1_alone_count", 64'(bus.count), 64'd2);
    check("lane1_alone_head", 64'(bus.deq_packet[0][63:32]), 64'h100);
    bus.deq_ready = '0;
    enq2(2'b11, mk(1'b0, 32'h1f0, InstAdd), mk(1'b1, 32'h108, InstAdd));
    tick();
    check("drop_invalid_pkt", 64'(bus.count), 64'd3);
    enq2(2'b01, mk(1'b1, 32'h10c, InstAdd), mk(1'b1, 32'h110, InstAdd));
    tick();
    check("prefix_lane1_ign", 64'(bus.count), 64'd4);
    bus.enq_valid = '0;
    bus.deq_ready = 2'b11;
    check("pfx_pc0", 64'(bus.deq_packet[0][63:32]), 64'h100);
    check("pfx_pc1", 64'(bus.deq_packet[1][63:32]), 64'h104);
    tick();
    check("pfx_pc2", 64'(bus.deq_packet[0][63:32]), 64'h108);
    check("pfx_pc3", 64'(bus.deq_packet[1][63:32]), 64'h10c);
    tick();
    check("pfx_empty", 64'(bus.count), 64'd0);
    bus.deq_ready = '0;

    // Branch throttle
    enq2(2'b11, mk(1'b1, 32'h200, InstBeq), mk(1'b1, 32'h204, InstBne));
    tick();
    enq2(2'b11, mk(1'b1, 32'h208, InstBeq), mk(1'b1, 32'h20c, InstAdd));
    tick();
    bus.enq_valid = '0;
    check("br_count4", 64'(bus.count), 64'd4);
    check("br_valid", 64'(bus.deq_valid), 64'd3);
    check("br_spec", 64'(bus.deq_spec), 64'd2);
    bus.deq_ready = 2'b11;
    tick();
    check("br_out2", 64'(bus.br_outstanding), 64'd2);
    check("br_throttled", 64'(bus.deq_valid), 64'd0);
    check("br_thr_spec0", 64'(bus.deq_spec[0]), 64'd1);
    tick();
    check("br_thr_hold", 64'(bus.count), 64'd2);
    bus.resolve = 1'b1;
    check("br_resolve_same", 64'(bus.deq_valid), 64'd0);
    tick();
    bus.resolve = 1'b0;
    check("br_out1", 64'(bus.br_outstanding), 64'd1);
    check("br_unblk_valid", 64'(bus.deq_valid), 64'd3);
    check("br_unblk_spec", 64'(bus.deq_spec), 64'd3);
    check("br_unblk_pc", 64'(bus.deq_packet[0][63:32]), 64'h208);
    tick();
    check("br_out2b", 64'(bus.br_outstanding), 64'd2);
    check("br_drained", 64'(bus.count), 64'd0);
    bus.deq_ready = '0;
    bus.resolve   = 1'b1;
    tick();
    tick();
    check("br_res_zero", 64'(bus.br_outstanding), 64'd0);
    tick();
    check("br_no_underflow", 64'(bus.br_outstanding), 64'd0);
    bus.resolve = 1'b0;

    // Halt
    enq2(2'b11, mk(1'b1, 32'h300, InstWfi), mk(1'b1, 32'h304, InstAdd));
    tick();
    check("halt_count", 64'(bus.count), 64'd1);
    check("halt_latched", 64'(bus.halt_latched), 64'd1);
    check("halt_enq_ready", 64'(bus.enq_ready), 64'd0);
    enq2(2'b11, mk(1'b1, 32'h308, InstAdd), mk(1'b1, 32'h30c, InstAdd));
    tick();
    check("halt_blocks", 64'(bus.count), 64'd1);
    bus.enq_valid = '0;
    bus.kill      = 1'b1;
    tick();
    bus.kill = 1'b0;
    check("kill_halt", 64'(bus.halt_latched), 64'd0);
    check("kill_h_count", 64'(bus.count), 64'd0);

    // Kill collision with a pending branch
    enq2(2'b11, mk(1'b1, 32'h400, InstBeq), mk(1'b1, 32'h404, InstAdd));
    tick();
    bus.enq_valid = '0;
    bus.deq_ready = 2'b11;
    tick();
    bus.deq_ready = '0;
    check("kc_br1", 64'(bus.br_outstanding), 64'd1);
    enq2(2'b11, mk(1'b1, 32'h408, InstBeq), mk(1'b1, 32'h40c, InstAdd));
    tick();
    enq2(2'b11, mk(1'b1, 32'h410, InstAdd), mk(1'b1, 32'h414, InstAdd));
    tick();
    check("kc_count4", 64'(bus.count), 64'd4);
    enq2(2'b11, mk(1'b1, 32'h418, InstAdd), mk(1'b1, 32'h41c, InstAdd));
    bus.deq_ready = 2'b11;
    bus.kill      = 1'b1;
    check("kc_prekill_valid", 64'(bus.deq_valid), 64'd3);
    tick();
    bus.kill      = 1'b0;
    bus.enq_valid = '0;
    bus.deq_ready = '0;
    check("kc_count", 64'(bus.count), 64'd0);
    check("kc_br", 64'(bus.br_outstanding), 64'd0);
    check("kc_halt", 64'(bus.halt_latched), 64'd0);
    check("kc_valid", 64'(bus.deq_valid), 64'd0);
    check("kc_ready", 64'(bus.enq_ready), 64'd1);

    // Wrap-around streaming
    bus.deq_ready = 2'b11;
    for (int k = 0; k < 20; k++) begin
      enq2(2'b11, mk(1'b1, 32'(32'h500 + k * 8), InstAdd),
           mk(1'b1, 32'(32'h504 + k * 8), InstAdd));
      if (k == 0) begin
        check("no_bypass", 64'(bus.deq_valid), 64'd0);
      end else begin
        check("wrap_valid", 64'(bus.deq_valid), 64'd3);
        check("wrap_pc0", 64'(bus.deq_packet[0][63:32]), 64'(32'h500 + (k - 1) * 8));
        check("wrap_pc1", 64'(bus.deq_packet[1][63:32]), 64'(32'h504 + (k - 1) * 8));
      end
      tick();
    end
    bus.enq_valid = '0;
    check("wrap_last", 64'(bus.deq_packet[0][63:32]), 64'(32'h500 + 19 * 8));
    tick();
    check("wrap_empty", 64'(bus.count), 64'd0);
    bus.deq_ready = '0;

    // Asynchronous reset at count 5
    enq2(2'b11, mk(1'b1, 32'h600, InstBeq), mk(1'b1, 32'h604, InstAdd));
    tick();
    enq2(2'b11, mk(1'b1, 32'h608, InstAdd), mk(1'b1, 32'h60c, InstAdd));
    tick();
    enq2(2'b01, mk(1'b1, 32'h610, InstAdd), mk(1'b1, 32'h614, InstAdd));
    tick();
    bus.enq_valid = '0;
    check("ar_count5", 64'(bus.count), 64'd5);
    #2 reset = 1'b0;
    #1;
    check("ar_count", 64'(bus.count), 64'd0);
    check("ar_valid", 64'(bus.deq_valid), 64'd0);
    check("ar_ready", 64'(bus.enq_ready), 64'd1);
    #3 reset = 1'b1;
    tick();
    check("ar_after", 64'(bus.count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Parametrised, multi-lane instruction buffer that decouples fetch from the issue/decode stage.
- Accepts up to ENQ_WIDTH IF_ID_PACKETs per cycle and presents up to DEQ_WIDTH packets per cycle, in program order, to N-wide decode/dispatch.
- Tags each presented packet as speculative while conditional branches are unresolved, and throttles unresolved branches to MAX_BR.
- Latches halt (WFI) to stop fetch. Flushes completely on kill.

Parameters:
DEPTH, 8, number of entries; power of 2, >= max(ENQ_WIDTH, DEQ_WIDTH)
ENQ_WIDTH, 2, fetch lanes written per cycle
DEQ_WIDTH, 2, issue lanes presented per cycle
MAX_BR, 2, maximum conditional branches dequeued but not yet resolved

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
enq_valid  input  ENQ_WIDTH  per-lane packet valid; only the contiguous prefix from lane 0 counts
enq_packet  input  ENQ_WIDTH x IF_ID_PACKET  fetched packets, lane 0 oldest
enq_ready  output  1  group accept: free slots >= ENQ_WIDTH and no halt latched
deq_valid  output  DEQ_WIDTH  lane i holds the i-th oldest entry and is issuable
deq_packet  output  DEQ_WIDTH x IF_ID_PACKET  head entries, lane 0 oldest
deq_spec  output  DEQ_WIDTH  entry issues under an unresolved conditional branch
deq_ready  input  DEQ_WIDTH  consumer accepts the lane
kill  input  1  mispredict flush
resolve  input  1  one outstanding conditional branch resolved correctly
count  output  $clog2(DEPTH+1)  occupied entries
br_outstanding  output  $clog2(MAX_BR+1)  dequeued, unresolved conditional branches
halt_latched  output  1  a WFI has been enqueued

Behaviour:
- Reset (reset==0, asynchronous):
  - Pointers, count, br_outstanding and halt_latched all go to 0.
  - Outputs: deq_valid all 0, enq_ready 1, deq_spec 0, deq_packet don't-care.
- State:
  - Circular array of DEPTH entries.
  - head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is separate, so full and empty are unambiguous.
- Enqueue:
  - enq_ready is combinational from registered state only: (DEPTH-count >= ENQ_WIDTH) && !halt_latched. It does not depend on same-cycle dequeue.
  - The group fires when enq_ready && enq_valid[0].
  - Lanes are written in order up to the first lane whose enq_valid==0. Later lanes are ignored even if their valid is set.
  - Invalid packets (packet.valid==0) inside the prefix are dropped, not stored.
- Halt:
  - A lane with inst==32'h10500073 (WFI) is stored.
  - Lanes after it in the same group are dropped.
  - halt_latched is set at the clock edge and held until kill or reset.
- Dequeue:
  - deq_valid[i] = 1 iff count > i and the branch throttle permits it.
  - Lane i fires iff deq_valid[j] && deq_ready[j] for all j <= i, so consumption is a strict in-order prefix.
  - head advances by the number of fired lanes. count updates as count + enq_n - deq_n.
  - No bypass: an entry is presentable no earlier than the cycle after it is written, so minimum latency is 1 cycle.
- Branch tracking:
  - A conditional branch is an entry with inst[6:0]==7'b1100011.
  - b_i is the number of conditional branches in lanes 0..i-1 at the head.
  - deq_spec[i] = (br_outstanding + b_i) > 0.
  - A branch at lane i is throttled (deq_valid[i]=0, which also blocks all later lanes) when br_outstanding + b_i >= MAX_BR.
  - Next br_outstanding = br_outstanding + (fired branches) - resolve.
  - resolve when br_outstanding==0 and no branch fires is ignored; the counter never underflows.
  - Simultaneous resolve and branch dequeue apply as a net change.
  - The throttle uses the registered br_outstanding; a same-cycle resolve does not unblock a branch until the next cycle.
- Kill (highest priority, synchronous):
  - At the edge: head=tail=0, count=0, br_outstanding=0, halt_latched=0.
  - Same-cycle enqueue and dequeue do not update state.
  - deq_valid is still driven from pre-kill state that cycle. The consumer must qualify its own writes with kill.
- Full:
  - When count==DEPTH, enq_ready=0.
  - Enqueue requires room for a whole group: with DEPTH=8, ENQ_WIDTH=2 and count=7, enq_ready=0.
- Reset mid-operation: asynchronously clears all state, including in-flight branch count.

Test Plan:
1. Fill/drain:
   - Stimulus: enqueue 4 groups of 2 ALU packets with deq_ready=0.
   - Response: count=8, enq_ready=0. Then deq_ready=2'b11 drains 2 per cycle in PC order. count reaches 0 after 4 cycles and enq_ready=1.
2. Prefix rules:
   - Stimulus: enq_valid=2'b10 (lane 0 invalid); then deq_ready=2'b10.
   - Response: nothing is written, count stays 0. Lane 1 never fires without lane 0; head does not move.
3. Branch throttle:
   - Stimulus: enqueue BEQ, BNE, BEQ, ADD with MAX_BR=2 and deq_ready all 1.
   - Response: BEQ and BNE dequeue, with deq_spec = 0 and 1 respectively; br_outstanding=2. The third BEQ holds deq_valid[0]=0.
   - Then pulse resolve: br_outstanding=1, the third BEQ issues next cycle with deq_spec=1, and br_outstanding returns to 2.
4. Halt:
   - Stimulus: group {WFI, ADD}.
   - Response: only WFI stored (count=1), halt_latched=1, enq_ready=0 on following cycles with enq_valid asserted.
5. Kill collision:
   - Stimulus: kill in the same cycle as an enqueue fire and a dequeue with a pending branch count.
   - Response: next cycle count=0, br_outstanding=0, halt_latched=0, deq_valid=0, enq_ready=1.
6. Async reset:
   - Stimulus: drive reset low mid-cycle at count=5.
   - Response: count=0 and deq_valid=0 immediately, without waiting for a clock edge. Wrap-around is checked by 20 enqueue/dequeue cycles with head passing index 7→0 and PC order preserved.
